// File: rtl/i2c_scl_gen.sv
// SCL timing generator: divides clk into four quarter phases plus a stretch-aware
// high-wait, drives SCL open-drain and emits one-cycle edge strobes for the master FSM.
module i2c_scl_gen #(
   parameter int          DIV_W  = 16,
   parameter logic [15:0] TO_CYC = 16'hFFFF
) (
   input  logic             clk,
   input  logic             resetN,
   input  logic             en,
   input  logic [DIV_W-1:0] div,
   input  logic             scl_en,
   input  logic             scl_in,
   output logic             scl_oe,
   output logic             scl_negedge,
   output logic             scl_posedge,
   output logic             scl_mid_high,
   output logic             stretch,
   output logic             timeout
);

   typedef enum logic [2:0] {
      IDLE,
      LOW_A,
      LOW_B,
      HIGH_WAIT,
      HIGH_A,
      HIGH_B
   } state_t;

   localparam logic [15:0] TO_LAST = TO_CYC - 16'd1;

   state_t           state;
   logic [DIV_W-1:0] q_cnt;
   logic [DIV_W-1:0] div_l;
   logic [DIV_W-1:0] div_eff_in;
   logic [DIV_W-1:0] div_l_m1;
   logic             drv_l;
   logic [15:0]      s_cnt;
   logic [1:0]       sync_ff;
   logic             scl_sync;
   logic             q_done;
   logic             run_ok;

   always_comb begin
      div_eff_in = (div < DIV_W'(2)) ? DIV_W'(2) : div;
      div_l_m1   = div_l - DIV_W'(1);
      scl_sync   = sync_ff[1];
      q_done     = (q_cnt == '0);
      run_ok     = en && !timeout;
   end

   // Line sampler resets to "released" so the first high-wait never sees a stale low.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         sync_ff <= '1;
      end else begin
         sync_ff <= {sync_ff[0], scl_in};
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state        <= IDLE;
         q_cnt        <= '0;
         div_l        <= '0;
         drv_l        <= 1'b0;
         s_cnt        <= '0;
         scl_oe       <= 1'b0;
         scl_negedge  <= 1'b0;
         scl_posedge  <= 1'b0;
         scl_mid_high <= 1'b0;
         stretch      <= 1'b0;
         timeout      <= 1'b0;
      end else begin
         scl_negedge  <= 1'b0;
         scl_posedge  <= 1'b0;
         scl_mid_high <= 1'b0;
         stretch      <= 1'b0;
         if (!en) begin
            timeout <= 1'b0;
         end

         case (state)
            IDLE: begin
               scl_oe <= 1'b0;
               if (run_ok) begin
                  state       <= LOW_A;
                  div_l       <= div_eff_in;
                  drv_l       <= scl_en;
                  q_cnt       <= div_eff_in - DIV_W'(1);
                  scl_oe      <= scl_en;
                  scl_negedge <= 1'b1;
               end
            end

            LOW_A: begin
               if (q_done) begin
                  state <= LOW_B;
                  q_cnt <= div_l_m1;
               end else begin
                  q_cnt <= q_cnt - DIV_W'(1);
               end
            end

            LOW_B: begin
               if (q_done) begin
                  state  <= HIGH_WAIT;
                  scl_oe <= 1'b0;
                  s_cnt  <= '0;
               end else begin
                  q_cnt <= q_cnt - DIV_W'(1);
               end
            end

            // When not driving, the line state is irrelevant and the wait is a single cycle.
            HIGH_WAIT: begin
               if (scl_sync || !drv_l) begin
                  state       <= HIGH_A;
                  q_cnt       <= div_l_m1;
                  scl_posedge <= 1'b1;
                  s_cnt       <= '0;
               end else if (s_cnt == TO_LAST) begin
                  state   <= IDLE;
                  timeout <= 1'b1;
                  s_cnt   <= '0;
               end else begin
                  s_cnt   <= s_cnt + 16'd1;
                  stretch <= 1'b1;
               end
            end

            HIGH_A: begin
               if (q_done) begin
                  state        <= HIGH_B;
                  q_cnt        <= div_l_m1;
                  scl_mid_high <= 1'b1;
               end else begin
                  q_cnt <= q_cnt - DIV_W'(1);
               end
            end

            HIGH_B: begin
               if (q_done) begin
                  if (run_ok) begin
                     state       <= LOW_A;
                     div_l       <= div_eff_in;
                     drv_l       <= scl_en;
                     q_cnt       <= div_eff_in - DIV_W'(1);
                     scl_oe      <= scl_en;
                     scl_negedge <= 1'b1;
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  q_cnt <= q_cnt - DIV_W'(1);
               end
            end

            default: begin
               state  <= IDLE;
               scl_oe <= 1'b0;
            end
         endcase
      end
   end

endmodule
